periph_bus_arb: RTL

//  Two-master arbiter for the shared 12-bit peripheral register bus (GPIO and siblings).

---
 rtl/periph_bus_arb_pkg.sv | 14 +
 rtl/periph_bus_arb_rr_arb2.sv | 19 +
 rtl/periph_bus_arb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/periph_bus_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package periph_bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_TURN   = 2'd2
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEFAULT = 255;
   localparam int ADDR_W              = 12;
   localparam int DATA_W              = 32;

endpackage

// File: rtl/periph_bus_arb_rr_arb2.sv
// Two-input round-robin picker. A sole requester wins outright; on a tie the
// master that was not granted last time wins. The last-grant flop lives in the parent.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);

   // grant is the index of the winning master
   always_comb begin
      grant = ~last;
      if (req == 2'b01) begin
         grant = 1'b0;
      end else if (req == 2'b10) begin
         grant = 1'b1;
      end
   end

endmodule

// File: rtl/periph_bus_arb.sv
// Two-master arbiter for the 12-bit peripheral register bus.
// state  | meaning
// IDLE   | bus free; arbitrate and latch the winner's request
// ACCESS | s_valid high; wait for s_ready or timeout
// TURN   | s_valid low turnaround; pulse ready to the winner
module periph_bus_arb
   import periph_bus_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
   parameter int CNT_W          = 8
) (
   input  logic              clk,
   input  logic              reset_,
   input  logic              m0_valid,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_valid,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic              s_sel,
   output logic              s_valid,
   output logic              s_wr,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic              s_ready,
   input  logic [DATA_W-1:0] s_rdata
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              last_grant;
   logic              grant_q;
   logic              grant_pick;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [CNT_W-1:0]  cnt;
   logic              any_req;
   logic              start;
   logic              access_done;
   logic              timed_out;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic              m0_err_q;
   logic              m1_err_q;

   assign any_req = m0_valid | m1_valid;
   assign start   = (state == ARB_IDLE) && any_req;

   rr_arb2 u_rr (
      .req   ({m1_valid, m0_valid}),
      .last  (last_grant),
      .grant (grant_pick)
   );

   // next-state decode; s_ready wins over a timeout landing on the same cycle
   always_comb begin
      state_nxt   = state;
      access_done = 1'b0;
      timed_out   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (any_req) state_nxt = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            if (s_ready) begin
               state_nxt   = ARB_TURN;
               access_done = 1'b1;
            end else if (TO_EN && (cnt == CNT_LAST)) begin
               state_nxt = ARB_TURN;
               timed_out = 1'b1;
            end
         end
         ARB_TURN: state_nxt = ARB_IDLE;
         default:  state_nxt = ARB_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= ARB_IDLE;
      else         state <= state_nxt;
   end

   // latch the winner's request so the slave sees it stable for the whole access
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else if (start) begin
         last_grant <= grant_pick;
         grant_q    <= grant_pick;
         wr_q       <= grant_pick ? m1_wr    : m0_wr;
         addr_q     <= grant_pick ? m1_addr  : m0_addr;
         wdata_q    <= grant_pick ? m1_wdata : m0_wdata;
      end
   end

   // timeout counter: cleared on grant, counts ACCESS cycles without s_ready, saturates
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= '0;
      end else if ((state == ARB_ACCESS) && (state_nxt == ARB_ACCESS) && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // per-master response registers; they hold until that master's next completion
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         m0_rdata_q <= '0;
         m0_err_q   <= 1'b0;
         m1_rdata_q <= '0;
         m1_err_q   <= 1'b0;
      end else if (access_done || timed_out) begin
         if (!grant_q) begin
            m0_rdata_q <= (access_done && !wr_q) ? s_rdata : '0;
            m0_err_q   <= timed_out;
         end else begin
            m1_rdata_q <= (access_done && !wr_q) ? s_rdata : '0;
            m1_err_q   <= timed_out;
         end
      end
   end

   assign s_sel    = (state == ARB_ACCESS);
   assign s_valid  = (state == ARB_ACCESS);
   assign s_wr     = wr_q;
   assign s_addr   = addr_q;
   assign s_wdata  = wdata_q;
   assign m0_ready = (state == ARB_TURN) && !grant_q;
   assign m1_ready = (state == ARB_TURN) &&  grant_q;
   assign m0_rdata = m0_rdata_q;
   assign m0_err   = m0_err_q;
   assign m1_rdata = m1_rdata_q;
   assign m1_err   = m1_err_q;

endmodule
